// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM slave for cpu_ram_if with LAT BUSY cycles before ACCESS.
// Define RAM_RESPONDER_ALIGN_CHECK_EN to report misaligned byte addresses as ERROR.
module ram_responder #(
  parameter int DEPTH = 1024,
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memREN,
  input  logic        memWEN,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11} state_e;
  logic          pend_q, pend_d, pop_q, pop_d;
  logic [3:0]    cnt_q, cnt_d, ecnt;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   mem_q [DEPTH];
  logic          req, match, oor, bad_align, wr;
  logic [AW-1:0] idx;
  state_e        st;
`ifdef RAM_RESPONDER_ALIGN_CHECK_EN
  assign bad_align = memaddr[1:0] != 2'b00;
`else
  logic [1:0] unused_lo;
  assign unused_lo = memaddr[1:0];
  assign bad_align = 1'b0;
`endif
  always_comb begin
    req = memREN | memWEN;
    match = pend_q && memaddr == paddr_q && memWEN == pop_q;
    ecnt = match ? cnt_q : 4'd0;
    oor = memaddr[31:AW+2] != '0;
    idx = memaddr[AW+1:2];
    st = !req ? FREE :
         ((memREN && memWEN) || bad_align || oor) ? ERROR :
         (ecnt == 4'(LAT)) ? ACCESS : BUSY;
    wr = st == ACCESS && memWEN;
    pend_d = st == BUSY;
    cnt_d = st == BUSY ? ecnt + 4'd1 : 4'd0;
    paddr_d = st == BUSY ? memaddr : paddr_q;
    pop_d = st == BUSY ? memWEN : pop_q;
    ramstate = st;
    ramload = (st == ACCESS && !memWEN) ? mem_q[idx] : 32'h0;
  end
  // Reset clears the whole array and overrides any write on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q <= 1'b0;
      cnt_q <= 4'd0;
      paddr_q <= 32'h0;
      pop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      paddr_q <= paddr_d;
      pop_q <= pop_d;
      if (wr) mem_q[idx] <= memstore;
    end
  end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: three responders (LAT 2, 0, 3) on shared stimulus, checked against a request-streak model.
module tb_ram_responder;
  localparam int DEPTH = 64;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, data = '0;
  logic [31:0] ld [3];
  logic [1:0]  st [3];
  int          total = 0, bad = 0;
  bit          armed = 1'b0;
  int          lit_k = -1;
  logic [1:0]  lit_st;
  logic [31:0] lit_ld;
  int          lat_of [3] = '{2, 0, 3};
  logic [31:0] mm [3][DEPTH];
  int          streak [3];
  logic [31:0] s_addr [3];
  bit          s_we [3];
  logic [1:0]  es [3];

  always #5 clk = ~clk;

  ram_responder #(.DEPTH(DEPTH), .LAT(2)) u0 (.CLK(clk), .RST(rst), .memREN(ren), .memWEN(wen),
    .memaddr(addr), .memstore(data), .ramload(ld[0]), .ramstate(st[0]));
  ram_responder #(.DEPTH(DEPTH), .LAT(0)) u1 (.CLK(clk), .RST(rst), .memREN(ren), .memWEN(wen),
    .memaddr(addr), .memstore(data), .ramload(ld[1]), .ramstate(st[1]));
  ram_responder #(.DEPTH(DEPTH), .LAT(3)) u2 (.CLK(clk), .RST(rst), .memREN(ren), .memWEN(wen),
    .memaddr(addr), .memstore(data), .ramload(ld[2]), .ramstate(st[2]));

  task automatic chk(string nm, int k, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h", nm, k, a, e);
    end
  endtask

  // Expected response: how many cycles this exact request has already waited decides BUSY vs ACCESS.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit          mis;
      int          waited;
      logic [31:0] eld;
`ifdef RAM_RESPONDER_ALIGN_CHECK_EN
      mis = addr[1:0] != 2'b00;
`else
      mis = 1'b0;
`endif
      waited = (streak[k] > 0 && s_addr[k] == addr && s_we[k] == wen) ? streak[k] : 0;
      if (!(ren || wen)) es[k] = 2'b00;
      else if ((ren && wen) || mis || addr >= DEPTH * 4) es[k] = 2'b11;
      else es[k] = (waited == lat_of[k]) ? 2'b10 : 2'b01;
      streak[k] = (es[k] == 2'b01) ? waited + 1 : 0;
      eld = (es[k] == 2'b10 && ren) ? mm[k][(addr >> 2) % DEPTH] : 32'h0;
      if (armed) begin
        chk("state", k, 32'(st[k]), 32'(es[k]));
        chk("load", k, ld[k], eld);
        if (lit_k == k) begin
          chk("lit_state", k, 32'(st[k]), 32'(lit_st));
          chk("lit_load", k, ld[k], lit_ld);
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        streak[k] = 0;
        for (int i = 0; i < DEPTH; i++) mm[k][i] = 32'h0;
      end else begin
        if (es[k] == 2'b10 && wen) mm[k][(addr >> 2) % DEPTH] = data;
        if (es[k] == 2'b01) begin
          s_addr[k] = addr;
          s_we[k] = wen;
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic rs, input int k, input logic [1:0] s, input logic [31:0] l);
    @(posedge clk);
    #1;
    ren = r; wen = w; addr = a; data = d; rst = rs;
    lit_k = k; lit_st = s; lit_ld = l;
  endtask

  task automatic idle(input int k);
    step(0, 0, 32'h0, 32'h0, 0, k, 2'b00, 32'h0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      streak[k] = 0;
      s_addr[k] = '0;
      s_we[k] = 1'b0;
      es[k] = 2'b00;
    end
    step(0, 0, 0, 0, 1, 0, 2'b00, 0);
    step(0, 0, 0, 0, 1, 0, 2'b00, 0);
    idle(0);
    step(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 2'b01, 0);
    step(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 2'b01, 0);
    step(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 2'b10, 0);
    idle(0);
    step(1, 0, 32'h40, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h40, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h40, 0, 0, 0, 2'b10, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 1, 2'b00, 0);
    step(1, 0, 32'h0, 0, 0, 1, 2'b10, 0);
    step(1, 0, 32'h0, 0, 0, 1, 2'b10, 0);
    step(1, 0, 32'h0, 0, 0, 1, 2'b10, 0);
    idle(2);
    step(1, 0, 32'h10, 0, 0, 2, 2'b01, 0);
    step(1, 0, 32'h10, 0, 0, 2, 2'b01, 0);
    step(1, 0, 32'h14, 0, 0, 2, 2'b01, 0);
    step(1, 0, 32'h14, 0, 0, 2, 2'b01, 0);
    step(1, 0, 32'h14, 0, 0, 2, 2'b01, 0);
    step(1, 0, 32'h14, 0, 0, 2, 2'b10, 0);
    idle(0);
    step(0, 1, 32'h8, 32'hA5A5A5A5, 0, 0, 2'b01, 0);
    step(0, 1, 32'h8, 32'hA5A5A5A5, 0, 0, 2'b01, 0);
    step(0, 1, 32'h8, 32'hA5A5A5A5, 0, 0, 2'b10, 0);
    idle(0);
    step(1, 1, 32'h8, 32'hFFFFFFFF, 0, 0, 2'b11, 0);
    step(1, 1, 32'h8, 32'hFFFFFFFF, 0, 1, 2'b11, 0);
    idle(0);
    step(1, 0, 32'h8, 0, 0, 1, 2'b10, 32'hA5A5A5A5);
    step(1, 0, 32'h8, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h8, 0, 0, 0, 2'b10, 32'hA5A5A5A5);
    step(1, 0, DEPTH * 4, 0, 0, 0, 2'b11, 0);
    step(1, 0, 32'hC0000040, 0, 0, 1, 2'b11, 0);
    idle(0);
    step(0, 1, 32'h30, 32'h77, 0, 0, 2'b01, 0);
    idle(0);
    step(1, 0, 32'h30, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h30, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h30, 0, 0, 0, 2'b10, 0);
    step(0, 0, 0, 0, 1, -1, 2'b00, 0);
    step(0, 1, 32'h20, 32'h12345678, 0, 0, 2'b01, 0);
    step(0, 1, 32'h20, 32'h12345678, 0, 0, 2'b01, 0);
    step(0, 1, 32'h20, 32'h12345678, 1, 0, 2'b10, 0);
    idle(0);
    step(1, 0, 32'h20, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h20, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h20, 0, 0, 0, 2'b10, 0);
    idle(0);
    step(0, 1, 32'h40, 32'h0BADF00D, 0, 0, 2'b01, 0);
    step(0, 1, 32'h40, 32'h0BADF00D, 0, 0, 2'b01, 0);
    step(0, 1, 32'h40, 32'h0BADF00D, 0, 0, 2'b10, 0);
    idle(0);
`ifdef RAM_RESPONDER_ALIGN_CHECK_EN
    step(1, 0, 32'h42, 0, 0, 0, 2'b11, 0);
    step(1, 0, 32'h42, 0, 0, 0, 2'b11, 0);
    step(1, 0, 32'h42, 0, 0, 0, 2'b11, 0);
`else
    step(1, 0, 32'h42, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h42, 0, 0, 0, 2'b01, 0);
    step(1, 0, 32'h42, 0, 0, 0, 2'b10, 32'h0BADF00D);
`endif
    idle(0);
    idle(-1);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
